// File: rtl/atm_dispense_ctrl.sv
// Withdrawal sequencer: validates the amount, plans a greedy two-cassette note split,
// dispenses one note per req/ack handshake and returns the debited balance.
module atm_dispense_ctrl #(
  parameter int unsigned AMT_W   = 16,
  parameter int unsigned NOTE_HI = 500,
  parameter int unsigned NOTE_LO = 100,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cancel,
  input  logic [AMT_W-1:0] amount,
  input  logic [AMT_W-1:0] balance_in,
  input  logic [CNT_W-1:0] cass_hi,
  input  logic [CNT_W-1:0] cass_lo,
  input  logic             disp_ack,
  output logic             disp_req,
  output logic             disp_sel,
  output logic             busy,
  output logic             done,
  output logic             ok,
  output logic [2:0]       err_code,
  output logic [AMT_W-1:0] balance_out,
  output logic             balance_we,
  output logic [CNT_W-1:0] notes_hi,
  output logic [CNT_W-1:0] notes_lo
);

  localparam int unsigned      WdW    = $clog2(TIMEOUT + 1);
  localparam logic [AMT_W-1:0] HiAmt  = AMT_W'(NOTE_HI);
  localparam logic [AMT_W-1:0] LoAmt  = AMT_W'(NOTE_LO);
  localparam logic [WdW-1:0]   WdLast = WdW'(TIMEOUT - 1);

  localparam logic [2:0] ErrNone      = 3'd0;
  localparam logic [2:0] ErrInvalid   = 3'd1;
  localparam logic [2:0] ErrNoFunds   = 3'd2;
  localparam logic [2:0] ErrNoCash    = 3'd3;
  localparam logic [2:0] ErrJam       = 3'd4;
  localparam logic [2:0] ErrCancelled = 3'd5;

  typedef enum logic [2:0] {
    StIdle, StCheck, StPlan, StReq, StGap, StCommit, StDone
  } state_e;

  state_e           state_q, state_d;
  logic [AMT_W-1:0] bal_q, bal_d, rem_q, rem_d;
  logic [CNT_W-1:0] cass_hi_q, cass_hi_d, cass_lo_q, cass_lo_d;
  logic [CNT_W-1:0] plan_hi_q, plan_hi_d, plan_lo_q, plan_lo_d;
  logic [CNT_W-1:0] notes_hi_q, notes_hi_d, notes_lo_q, notes_lo_d;
  logic [2:0]       err_q, err_d;
  logic [WdW-1:0]   wdog_q, wdog_d;
  logic [AMT_W-1:0] dispensed;
  logic             hi_pending;

  assign dispensed  = AMT_W'(notes_hi_q) * HiAmt + AMT_W'(notes_lo_q) * LoAmt;
  assign hi_pending = notes_hi_q < plan_hi_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      bal_q      <= '0;
      rem_q      <= '0;
      cass_hi_q  <= '0;
      cass_lo_q  <= '0;
      plan_hi_q  <= '0;
      plan_lo_q  <= '0;
      notes_hi_q <= '0;
      notes_lo_q <= '0;
      err_q      <= ErrNone;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      bal_q      <= bal_d;
      rem_q      <= rem_d;
      cass_hi_q  <= cass_hi_d;
      cass_lo_q  <= cass_lo_d;
      plan_hi_q  <= plan_hi_d;
      plan_lo_q  <= plan_lo_d;
      notes_hi_q <= notes_hi_d;
      notes_lo_q <= notes_lo_d;
      err_q      <= err_d;
      wdog_q     <= wdog_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bal_d      = bal_q;
    rem_d      = rem_q;
    cass_hi_d  = cass_hi_q;
    cass_lo_d  = cass_lo_q;
    plan_hi_d  = plan_hi_q;
    plan_lo_d  = plan_lo_q;
    notes_hi_d = notes_hi_q;
    notes_lo_d = notes_lo_q;
    err_d      = err_q;
    wdog_d     = wdog_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StCheck;
          bal_d      = balance_in;
          rem_d      = amount;
          cass_hi_d  = cass_hi;
          cass_lo_d  = cass_lo;
          plan_hi_d  = '0;
          plan_lo_d  = '0;
          notes_hi_d = '0;
          notes_lo_d = '0;
          err_d      = ErrNone;
        end
      end
      StCheck: begin
        state_d = StDone;
        if (cancel) begin
          err_d = ErrCancelled;
        end else if (rem_q == '0 || (rem_q % LoAmt) != '0) begin
          err_d = ErrInvalid;
        end else if (rem_q > bal_q) begin
          err_d = ErrNoFunds;
        end else begin
          state_d = StPlan;
        end
      end
      StPlan: begin
        if (cancel) begin
          err_d   = ErrCancelled;
          state_d = StDone;
        end else if (rem_q == '0) begin
          wdog_d  = '0;
          state_d = StReq;
        end else if (rem_q >= HiAmt && plan_hi_q < cass_hi_q) begin
          rem_d     = rem_q - HiAmt;
          plan_hi_d = plan_hi_q + CNT_W'(1);
        end else if (plan_lo_q == cass_lo_q) begin
          err_d   = ErrNoCash;
          state_d = StDone;
        end else begin
          // rem is a nonzero multiple of NOTE_LO here, so a low note always fits
          rem_d     = rem_q - LoAmt;
          plan_lo_d = plan_lo_q + CNT_W'(1);
        end
      end
      StReq: begin
        if (disp_ack) begin
          if (hi_pending) notes_hi_d = notes_hi_q + CNT_W'(1);
          else            notes_lo_d = notes_lo_q + CNT_W'(1);
          state_d = StGap;
        end else if (wdog_q == WdLast) begin
          err_d   = ErrJam;
          state_d = StCommit;
        end else begin
          wdog_d = wdog_q + WdW'(1);
        end
      end
      StGap: begin
        wdog_d  = '0;
        state_d = (hi_pending || notes_lo_q < plan_lo_q) ? StReq : StCommit;
      end
      StCommit: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    disp_req    = (state_q == StReq);
    disp_sel    = (state_q == StReq) && hi_pending;
    busy        = (state_q != StIdle);
    done        = (state_q == StDone);
    ok          = done && (err_q == ErrNone);
    err_code    = err_q;
    balance_we  = (state_q == StCommit) && (dispensed != '0);
    balance_out = balance_we ? (bal_q - dispensed) : '0;
    notes_hi    = notes_hi_q;
    notes_lo    = notes_lo_q;
  end

endmodule

// File: tb/tb_atm_dispense_ctrl.sv
// Scoreboard bench for atm_dispense_ctrl: an arithmetic withdrawal model fills expectation
// queues; a monitor checks note requests, balance writes and completions as they appear.
module tb_atm_dispense_ctrl;

  localparam int AMT_W   = 16;
  localparam int NOTE_HI = 500;
  localparam int NOTE_LO = 100;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 16;

  logic             clk, reset, start, cancel, disp_ack;
  logic [AMT_W-1:0] amount, balance_in, balance_out;
  logic [CNT_W-1:0] cass_hi, cass_lo, notes_hi, notes_lo;
  logic             disp_req, disp_sel, busy, done, ok, balance_we;
  logic [2:0]       err_code;

  atm_dispense_ctrl #(
    .AMT_W(AMT_W), .NOTE_HI(NOTE_HI), .NOTE_LO(NOTE_LO), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cancel(cancel), .amount(amount),
    .balance_in(balance_in), .cass_hi(cass_hi), .cass_lo(cass_lo), .disp_ack(disp_ack),
    .disp_req(disp_req), .disp_sel(disp_sel), .busy(busy), .done(done), .ok(ok),
    .err_code(err_code), .balance_out(balance_out), .balance_we(balance_we),
    .notes_hi(notes_hi), .notes_lo(notes_lo)
  );

  typedef struct {
    int amount; int balance; int chi; int clo; int ack_limit; int cancel_k;
  } txn_t;
  typedef struct { int err; int hi; int lo; } done_t;

  bit    sel_q[$];
  int    bal_q[$];
  done_t done_q[$];
  int    checks = 0;
  int    errors = 0;
  int    note_idx = 0;
  int    ack_limit = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected outcome straight from the withdrawal rules: greedy split, then delivery.
  task automatic push_expect(input txn_t t);
    int hi_plan, lo_need, p, n, dlv, hi_d, lo_d, err;
    bit nocash;
    hi_plan = t.amount / NOTE_HI;
    if (hi_plan > t.chi) hi_plan = t.chi;
    lo_need = (t.amount - hi_plan * NOTE_HI) / NOTE_LO;
    nocash  = lo_need > t.clo;
    p       = nocash ? hi_plan + t.clo + 1 : hi_plan + lo_need + 1;
    hi_d = 0;
    lo_d = 0;
    if (t.cancel_k == 1)                                  err = 5;
    else if (t.amount == 0 || t.amount % NOTE_LO != 0)    err = 1;
    else if (t.amount > t.balance)                        err = 2;
    else if (t.cancel_k >= 2 && t.cancel_k <= p + 1)      err = 5;
    else if (nocash)                                      err = 3;
    else begin
      n   = hi_plan + lo_need;
      dlv = (t.ack_limit < n) ? t.ack_limit : n;
      for (int i = 0; i < n && i <= dlv; i++) sel_q.push_back(i < hi_plan);
      hi_d = (dlv < hi_plan) ? dlv : hi_plan;
      lo_d = dlv - hi_d;
      err  = (dlv < n) ? 4 : 0;
      if (dlv > 0) bal_q.push_back(t.balance - hi_d * NOTE_HI - lo_d * NOTE_LO);
    end
    done_q.push_back('{err, hi_d, lo_d});
  endtask

  task automatic apply_inputs(input txn_t t);
    amount     = AMT_W'(t.amount);
    balance_in = AMT_W'(t.balance);
    cass_hi    = CNT_W'(t.chi);
    cass_lo    = CNT_W'(t.clo);
    ack_limit  = t.ack_limit;
    note_idx   = 0;
  endtask

  task automatic flush_and_reset();
    reset = 1'b0;
    #1;
    sel_q.delete();
    bal_q.delete();
    done_q.delete();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_txn(input txn_t t, output int cyc);
    bit got;
    push_expect(t);
    @(negedge clk);
    apply_inputs(t);
    start = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      start  = 1'b0;
      cancel = (t.cancel_k != 0 && cyc == t.cancel_k);
      if (done) got = 1'b1;
    end
    cancel = 1'b0;
    if (!got) begin
      chk("done_timeout", 0, 1);
      flush_and_reset();
    end
  endtask

  // Dispenser: acks after a random delay until the per-transaction ack budget runs out.
  initial begin
    int dly;
    disp_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (disp_req) begin
        if (note_idx < ack_limit) begin
          dly = $urandom_range(0, 3);
          repeat (dly) @(negedge clk);
          disp_ack = 1'b1;
          @(negedge clk);
          disp_ack = 1'b0;
          note_idx++;
        end else begin
          while (disp_req) @(negedge clk);
        end
      end
    end
  end

  initial begin
    bit    prev_req = 1'b0;
    bit    cur_sel = 1'b0;
    done_t e;
    int    b;
    forever begin
      @(negedge clk);
      if (disp_req) begin
        if (!prev_req) begin
          if (sel_q.size() == 0) chk("unexpected_disp_req", 1, 0);
          else cur_sel = sel_q.pop_front();
        end
        chk("disp_sel", int'(disp_sel), int'(cur_sel));
      end
      prev_req = disp_req;
      if (balance_we) begin
        if (bal_q.size() == 0) chk("unexpected_balance_we", 1, 0);
        else begin
          b = bal_q.pop_front();
          chk("balance_out", int'(balance_out), b);
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = done_q.pop_front();
          chk("err_code", int'(err_code), e.err);
          chk("ok", int'(ok), int'(e.err == 0));
          chk("notes_hi", int'(notes_hi), e.hi);
          chk("notes_lo", int'(notes_lo), e.lo);
          chk("busy_with_done", int'(busy), 1);
        end
      end
    end
  end

  initial begin
    txn_t dir[6];
    txn_t t;
    int   cyc;
    reset = 1'b0; start = 1'b0; cancel = 1'b0;
    amount = '0; balance_in = '0; cass_hi = '0; cass_lo = '0;
    #2;
    chk("reset_ctrl_outs", int'({disp_req, disp_sel, busy, done, ok, balance_we}), 0);
    chk("reset_err_code", int'(err_code), 0);
    chk("reset_notes", int'({notes_hi, notes_lo}), 0);
    chk("reset_balance_out", int'(balance_out), 0);
    @(negedge clk);
    reset = 1'b1;

    dir[0] = '{700, 1000, 5, 5, 99, 0};   // nominal: hi, lo, lo
    dir[1] = '{1000, 2000, 1, 3, 99, 0};  // cassette-limited
    dir[2] = '{250, 1000, 5, 5, 99, 0};   // not a note multiple
    dir[3] = '{600, 500, 5, 5, 99, 0};    // insufficient balance
    dir[4] = '{300, 1000, 0, 5, 1, 0};    // jam after first note
    dir[5] = '{1500, 2000, 1, 10, 99, 3}; // cancel while planning
    foreach (dir[i]) begin
      run_txn(dir[i], cyc);
      if (i == 2 || i == 3) chk("validation_latency_le3", int'(cyc <= 3), 1);
    end

    // Reset while a note is being requested.
    t = '{500, 1000, 1, 0, 0, 0};
    sel_q.push_back(1'b1);
    @(negedge clk);
    apply_inputs(t);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !disp_req; i++) @(negedge clk);
    chk("reached_req_before_reset", int'(disp_req), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("midreset_ctrl_outs", int'({disp_req, disp_sel, busy, done, ok, balance_we}), 0);
    chk("midreset_data_outs", int'({err_code, notes_hi, notes_lo}), 0);
    sel_q.delete();
    @(negedge clk);
    reset = 1'b1;
    run_txn('{1200, 1500, 3, 3, 99, 0}, cyc);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) t.amount = int'($urandom_range(0, 3000));
      else t.amount = int'($urandom_range(0, 30)) * NOTE_LO;
      t.balance   = int'($urandom_range(0, 4000));
      t.chi       = int'($urandom_range(0, 6));
      t.clo       = int'($urandom_range(0, 10));
      t.ack_limit = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 99;
      t.cancel_k  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_txn(t, cyc);
    end

    repeat (4) @(negedge clk);
    chk("sel_queue_drained", sel_q.size(), 0);
    chk("bal_queue_drained", bal_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/atm_dispense_ctrl.md
Name: atm_dispense_ctrl

Overview:
- Sequences a cash withdrawal once the ATM FSM has an amount entered.
- Flow: validates the amount against the account balance, plans a greedy note split from two cassettes, and drives the note dispenser one note at a time over a req/ack handshake.
- Returns the debited balance to the account register.
- Sits between the atm_fsm (start/done) and the dispenser mechanism.

Parameters:
- AMT_W, 16, width of amount and balance
- NOTE_HI, 500, value of high-denomination note
- NOTE_LO, 100, value of low-denomination note; every valid amount is a multiple of this
- CNT_W, 8, width of cassette and note counters
- TIMEOUT, 16, max cycles disp_req may wait for disp_ack

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin withdrawal
- cancel  in  1  abort request; honoured only before the first note
- amount  in  AMT_W  requested amount, sampled on start
- balance_in  in  AMT_W  current balance, sampled on start
- cass_hi  in  CNT_W  high notes available, sampled on start
- cass_lo  in  CNT_W  low notes available, sampled on start
- disp_ack  in  1  dispenser: note delivered (1-cycle pulse)
- disp_req  out  1  request one note
- disp_sel  out  1  0 = low note, 1 = high note
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse
- ok  out  1  valid with done; 1 = full amount dispensed
- err_code  out  3  0 none, 1 invalid, 2 insufficient, 3 no_cash, 4 jam, 5 cancelled; held until next start
- balance_out  out  AMT_W  new balance, valid with balance_we
- balance_we  out  1  one-cycle write strobe
- notes_hi  out  CNT_W  high notes dispensed this transaction
- notes_lo  out  CNT_W  low notes dispensed this transaction

Behaviour:
- Reset (reset=0, async): state IDLE, all outputs 0.
- Reset mid-transaction: abandons immediately; no balance_we, no done.
- States: IDLE, CHECK, PLAN, REQ, GAP, COMMIT, DONE.
- IDLE: start=1 latches amount, balance_in and cass_*. Clears err_code and notes_*. Moves to CHECK. start is ignored when not in IDLE.
- CHECK (1 cycle), in priority order:
  - amount==0 or amount not a multiple of NOTE_LO → err 1, go to DONE.
  - amount>balance → err 2, go to DONE.
  - Otherwise go to PLAN.
- PLAN: one subtraction per cycle from latched remainder rem.
  - If rem≥NOTE_HI and plan_hi<cass_hi: subtract NOTE_HI, plan_hi++.
  - Else if rem≥NOTE_LO: subtract NOTE_LO, plan_lo++.
  - If plan_lo would exceed cass_lo → err 3, go to DONE.
  - rem==0 → go to REQ.
  - Latency is plan_hi+plan_lo+1 cycles.
- cancel in CHECK or PLAN → err 5, go to DONE. cancel is ignored from REQ onward.
- REQ: disp_req=1, disp_sel=1 while high notes remain, then 0. disp_sel is stable while disp_req is high. A watchdog counts cycles in REQ.
  - disp_ack → increment notes_hi or notes_lo, go to GAP.
  - Watchdog reaches TIMEOUT without ack → err 4, go to COMMIT.
  - disp_ack seen outside REQ is ignored.
- GAP: disp_req=0 for exactly one cycle. Then REQ if notes remain, else COMMIT.
- COMMIT:
  - dispensed = notes_hi*NOTE_HI + notes_lo*NOTE_LO.
  - If dispensed>0: balance_out = latched balance − dispensed, balance_we=1 for one cycle.
  - Always go to DONE.
  - On jam, a partial debit of the dispensed value only.
- DONE: done=1 for one cycle; ok=1 iff err_code==0. busy drops with done. Return to IDLE.
- Arithmetic is unsigned. The balance never underflows, guaranteed by CHECK.
- Error paths from CHECK/PLAN never strobe balance_we.

Test Plan:
- Nominal: amount=700, balance=1000, cass_hi=5, cass_lo=5, ack 2 cycles after each req.
  - Required: sequence hi,lo,lo; notes_hi=1, notes_lo=2; balance_we with balance_out=300; done with ok=1, err_code=0.
- Cassette-limited: amount=1000, cass_hi=1, cass_lo=3.
  - Required: err 3; no disp_req; no balance_we; done with ok=0.
- Validation:
  - amount=250 → err 1.
  - amount=600, balance=500 → err 2.
  - Both cases: done within 3 cycles of start; disp_req never asserted.
- Jam: amount=300 (3 low notes); ack the first note, then withhold ack.
  - Required: after TIMEOUT cycles err 4; balance_out=balance−100; notes_lo=1; ok=0.
- Cancel and reset:
  - cancel during PLAN → err 5, no disp_req.
  - reset=0 asserted while in REQ → disp_req drops asynchronously, all outputs 0, no done or balance_we; a subsequent start works normally.
